// File: rtl/d_mem_4t.sv
// d_mem_4t: word-organised data RAM with byte-lane steering plus MMIO control registers for gpc_4t.
// Loads return one cycle later, right-aligned and zero-extended.
module d_mem_4t #(
    parameter logic [31:0] D_MEM_BASE  = 32'h0000_1000,
    parameter int          D_MEM_WORDS = 1024,
    parameter logic [31:0] CR_BASE     = 32'h0000_2000
) (
    input  logic        QClk,
    input  logic        RstQnnnH,
    input  logic [31:0] MemAdrsQ102H,
    input  logic [31:0] MemWrDataWQ102H,
    input  logic        CtrlMemWrQ102H,
    input  logic        CtrlMemRdQ102H,
    input  logic [3:0]  MemByteEnQ102H,
    output logic [31:0] MemRdDataQ103H,
    output logic        CrRstPcQnnnH,
    output logic [4:0]  CrRdPtrQnnnH,
    output logic        AccessErrQnnnH
);
    localparam int AW = $clog2(D_MEM_WORDS);

    logic [31:0] mem [D_MEM_WORDS];
    logic [31:0] ramOff, crOff, wrShift, memWord, crWord, rawWord, beMask, loadVal;
    logic [31:0] scratch, cycleCnt;
    logic [6:0]  laneSpread;
    logic [3:0]  lanes;
    logic [4:0]  bitOff;
    logic [1:0]  crSel;
    logic        ramHit, crHit, misaligned, accessErr, crWr;

    always_comb begin
        ramOff     = MemAdrsQ102H - D_MEM_BASE;
        crOff      = MemAdrsQ102H - CR_BASE;
        ramHit     = ramOff < 32'(4 * D_MEM_WORDS);
        crHit      = crOff < 32'd16;
        crSel      = MemAdrsQ102H[3:2];
        bitOff     = {MemAdrsQ102H[1:0], 3'b000};
        // bits pushed past lane 3 mark a misaligned access but the surviving lanes still act
        laneSpread = {3'b000, MemByteEnQ102H} << MemAdrsQ102H[1:0];
        lanes      = laneSpread[3:0];
        misaligned = (|laneSpread[6:4]) || (MemByteEnQ102H == 4'b0000);
        wrShift    = MemWrDataWQ102H << bitOff;
        memWord    = mem[ramOff[AW+1:2]];
        crWord     = (crSel == 2'd0) ? {31'b0, CrRstPcQnnnH} :
                     (crSel == 2'd1) ? {27'b0, CrRdPtrQnnnH} :
                     (crSel == 2'd2) ? scratch : cycleCnt;
        rawWord    = ramHit ? memWord : crHit ? crWord : 32'b0;
        beMask     = {{8{MemByteEnQ102H[3]}}, {8{MemByteEnQ102H[2]}},
                      {8{MemByteEnQ102H[1]}}, {8{MemByteEnQ102H[0]}}};
        loadVal    = CtrlMemWrQ102H ? 32'b0 : (rawWord >> bitOff) & beMask;
        accessErr  = (CtrlMemRdQ102H && CtrlMemWrQ102H) ||
                     ((CtrlMemRdQ102H || CtrlMemWrQ102H) && (misaligned || !(ramHit || crHit)));
        crWr       = CtrlMemWrQ102H && crHit;
    end

    // RAM is never cleared; reset only suppresses a store landing on the reset edge
    always_ff @(posedge QClk or posedge RstQnnnH) begin
        if (!RstQnnnH && CtrlMemWrQ102H && ramHit)
            for (int i = 0; i < 4; i++)
                if (lanes[i]) mem[ramOff[AW+1:2]][8*i +: 8] <= wrShift[8*i +: 8];
    end

    always_ff @(posedge QClk or posedge RstQnnnH) begin
        if (RstQnnnH) begin
            MemRdDataQ103H <= '0;
            CrRstPcQnnnH   <= 1'b0;
            CrRdPtrQnnnH   <= '0;
            scratch        <= '0;
            cycleCnt       <= '0;
            AccessErrQnnnH <= 1'b0;
        end else begin
            if (CtrlMemRdQ102H) MemRdDataQ103H <= loadVal;
            if (crWr && crSel == 2'd0 && lanes[0]) CrRstPcQnnnH <= wrShift[0];
            if (crWr && crSel == 2'd1 && lanes[0]) CrRdPtrQnnnH <= wrShift[4:0];
            if (crWr && crSel == 2'd2)
                for (int i = 0; i < 4; i++)
                    if (lanes[i]) scratch[8*i +: 8] <= wrShift[8*i +: 8];
            cycleCnt       <= cycleCnt + 32'd1;
            AccessErrQnnnH <= AccessErrQnnnH | accessErr;
        end
    end
endmodule

// File: tb/tb_d_mem_4t.sv
// tb_d_mem_4t: randomized and directed bench for d_mem_4t against a byte-level behavioural model.
module tb_d_mem_4t;
    logic        QClk = 1'b0;
    logic        RstQnnnH;
    logic [31:0] MemAdrsQ102H, MemWrDataWQ102H;
    logic        CtrlMemWrQ102H, CtrlMemRdQ102H;
    logic [3:0]  MemByteEnQ102H;
    logic [31:0] MemRdDataQ103H;
    logic        CrRstPcQnnnH;
    logic [4:0]  CrRdPtrQnnnH;
    logic        AccessErrQnnnH;

    d_mem_4t dut (
        .QClk(QClk), .RstQnnnH(RstQnnnH), .MemAdrsQ102H(MemAdrsQ102H),
        .MemWrDataWQ102H(MemWrDataWQ102H), .CtrlMemWrQ102H(CtrlMemWrQ102H),
        .CtrlMemRdQ102H(CtrlMemRdQ102H), .MemByteEnQ102H(MemByteEnQ102H),
        .MemRdDataQ103H(MemRdDataQ103H), .CrRstPcQnnnH(CrRstPcQnnnH),
        .CrRdPtrQnnnH(CrRdPtrQnnnH), .AccessErrQnnnH(AccessErrQnnnH)
    );

    always #5 QClk = ~QClk;

    int nCmp = 0, nBad = 0;
    bit enChk = 0;

    logic [31:0] mRam [1024];
    logic [31:0] eRd, mScr, mCyc, cycSetVal, v1;
    logic        eRstPc, eErr;
    logic [4:0]  eRdPtr;
    int          cycSetReq = 0, cycSetSeen = 0;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        nCmp++;
        if (got !== exp) begin
            nBad++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    function automatic logic [31:0] loadOf(logic [31:0] w, int off, logic [3:0] be);
        logic [31:0] r = 0;
        for (int i = 0; i < 4; i++)
            if (be[i] && i + off < 4) r[8*i +: 8] = w[8*(i+off) +: 8];
        return r;
    endfunction

    function automatic logic [31:0] storeOf(logic [31:0] w, logic [31:0] d, int off, logic [3:0] be);
        logic [31:0] r = w;
        for (int i = 0; i < 4; i++)
            if (be[i] && i + off < 4) r[8*(i+off) +: 8] = d[8*i +: 8];
        return r;
    endfunction

    function automatic logic misOf(int off, logic [3:0] be);
        logic m = (be == 4'b0);
        for (int i = 0; i < 4; i++)
            if (be[i] && i + off > 3) m = 1'b1;
        return m;
    endfunction

    always @(posedge QClk or posedge RstQnnnH) begin : model
        logic [31:0] a, cyc, crCur, crNew;
        logic ram, cr;
        int off, idx;
        if (RstQnnnH) begin
            eRd <= 0; eRstPc <= 0; eRdPtr <= 0; mScr <= 0; mCyc <= 0; eErr <= 0;
        end else begin
            a   = MemAdrsQ102H;
            ram = a >= 32'h1000 && a < 32'h2000;
            cr  = a >= 32'h2000 && a < 32'h2010;
            off = int'(a % 4);
            idx = int'((a - 32'h1000) / 4);
            cyc = (cycSetReq != cycSetSeen) ? cycSetVal : mCyc;
            cycSetSeen <= cycSetReq;
            case (a[3:2])
                2'd0: crCur = {31'b0, eRstPc};
                2'd1: crCur = {27'b0, eRdPtr};
                2'd2: crCur = mScr;
                default: crCur = cyc;
            endcase
            if (CtrlMemRdQ102H)
                eRd <= CtrlMemWrQ102H ? 32'b0 :
                       ram ? loadOf(mRam[idx], off, MemByteEnQ102H) :
                       cr  ? loadOf(crCur, off, MemByteEnQ102H) : 32'b0;
            if (CtrlMemWrQ102H && ram)
                mRam[idx] <= storeOf(mRam[idx], MemWrDataWQ102H, off, MemByteEnQ102H);
            if (CtrlMemWrQ102H && cr) begin
                crNew = storeOf(crCur, MemWrDataWQ102H, off, MemByteEnQ102H);
                if (a[3:2] == 2'd0) eRstPc <= crNew[0];
                if (a[3:2] == 2'd1) eRdPtr <= crNew[4:0];
                if (a[3:2] == 2'd2) mScr <= crNew;
            end
            mCyc <= cyc + 1;
            if ((CtrlMemRdQ102H && CtrlMemWrQ102H) ||
                ((CtrlMemRdQ102H || CtrlMemWrQ102H) && (misOf(off, MemByteEnQ102H) || !(ram || cr))))
                eErr <= 1'b1;
        end
    end

    always @(negedge QClk) begin
        if (enChk && !RstQnnnH) begin
            chk("rdData", MemRdDataQ103H, eRd);
            chk("rstPc", {31'b0, CrRstPcQnnnH}, {31'b0, eRstPc});
            chk("rdPtr", {27'b0, CrRdPtrQnnnH}, {27'b0, eRdPtr});
            chk("accessErr", {31'b0, AccessErrQnnnH}, {31'b0, eErr});
        end
    end

    task automatic req(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] be);
        @(negedge QClk);
        CtrlMemRdQ102H = rd; CtrlMemWrQ102H = wr;
        MemAdrsQ102H = a; MemWrDataWQ102H = d; MemByteEnQ102H = be;
        @(posedge QClk);
        #1;
    endtask

    task automatic doReset();
        @(negedge QClk);
        RstQnnnH = 1'b1; CtrlMemRdQ102H = 0; CtrlMemWrQ102H = 0;
        @(negedge QClk);
        RstQnnnH = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] be;
        logic [31:0] a;
        int r, c, off;
        RstQnnnH = 1; CtrlMemRdQ102H = 0; CtrlMemWrQ102H = 0;
        MemAdrsQ102H = 0; MemWrDataWQ102H = 0; MemByteEnQ102H = 0;
        repeat (2) @(negedge QClk);
        RstQnnnH = 0;
        enChk = 1;
        chk("resetRd", MemRdDataQ103H, 32'h0);
        chk("resetRstPc", {31'b0, CrRstPcQnnnH}, 32'h0);
        chk("resetRdPtr", {27'b0, CrRdPtrQnnnH}, 32'h0);
        chk("resetErr", {31'b0, AccessErrQnnnH}, 32'h0);
        for (int i = 0; i < 1024; i++) req(0, 1, 32'h1000 + 32'(4 * i), $urandom, 4'hF);

        req(0, 1, 32'h1000, 32'hDEADBEEF, 4'hF);
        req(0, 1, 32'h1001, 32'h55, 4'h1);
        req(1, 0, 32'h1000, 0, 4'hF); chk("lw1000", MemRdDataQ103H, 32'hDEAD55EF);
        req(1, 0, 32'h1002, 0, 4'h3); chk("lh1002", MemRdDataQ103H, 32'h0000DEAD);
        req(1, 0, 32'h1003, 0, 4'h1); chk("lb1003", MemRdDataQ103H, 32'h000000DE);
        req(0, 1, 32'h1FFC, 32'h12345678, 4'hF);
        req(1, 0, 32'h1FFC, 0, 4'hF); chk("b2bLast", MemRdDataQ103H, 32'h12345678);
        req(1, 0, 32'h1000, 0, 4'hF); chk("noAlias", MemRdDataQ103H, 32'hDEAD55EF);

        req(0, 1, 32'h2000, 32'h1, 4'hF); chk("crRstPc", {31'b0, CrRstPcQnnnH}, 32'h1);
        req(0, 1, 32'h2004, 32'h1F, 4'hF); chk("crRdPtr", {27'b0, CrRdPtrQnnnH}, 32'h1F);
        req(0, 1, 32'h2008, 32'hA5A5A5A5, 4'hF);
        req(1, 0, 32'h2008, 0, 4'hF); chk("scratch", MemRdDataQ103H, 32'hA5A5A5A5);
        req(0, 1, 32'h200C, 32'h7, 4'hF);
        req(1, 0, 32'h200C, 0, 4'hF); v1 = MemRdDataQ103H;
        repeat (4) req(0, 0, 0, 0, 4'h0);
        req(1, 0, 32'h200C, 0, 4'hF); chk("cycleDelta", MemRdDataQ103H - v1, 32'd5);

        req(1, 0, 32'h1001, 0, 4'hF);
        req(1, 0, 32'h2008, 0, 4'hF);
        #1 RstQnnnH = 1'b1;
        #1;
        chk("asyncRd", MemRdDataQ103H, 32'h0);
        chk("asyncRstPc", {31'b0, CrRstPcQnnnH}, 32'h0);
        chk("asyncRdPtr", {27'b0, CrRdPtrQnnnH}, 32'h0);
        chk("asyncErr", {31'b0, AccessErrQnnnH}, 32'h0);
        @(negedge QClk);
        RstQnnnH = 1'b0; CtrlMemRdQ102H = 0; CtrlMemWrQ102H = 0;
        req(1, 0, 32'h1FFC, 0, 4'hF); chk("ramKept", MemRdDataQ103H, 32'h12345678);

        doReset();
        chk("errClear", {31'b0, AccessErrQnnnH}, 32'h0);
        req(1, 0, 32'h1001, 0, 4'hF); chk("errMisalign", {31'b0, AccessErrQnnnH}, 32'h1);
        doReset();
        req(1, 0, 32'h1000, 0, 4'hF);
        req(1, 0, 32'h3000, 0, 4'hF);
        chk("unmappedRd", MemRdDataQ103H, 32'h0);
        chk("errUnmapped", {31'b0, AccessErrQnnnH}, 32'h1);
        doReset();
        req(1, 1, 32'h1004, 32'hCAFEF00D, 4'hF);
        chk("rdWrData", MemRdDataQ103H, 32'h0);
        chk("errRdWr", {31'b0, AccessErrQnnnH}, 32'h1);
        req(1, 0, 32'h1004, 0, 4'hF); chk("rdWrStored", MemRdDataQ103H, 32'hCAFEF00D);
        repeat (10) req(0, 0, 0, 0, 4'h0);
        chk("errSticky", {31'b0, AccessErrQnnnH}, 32'h1);

        @(negedge QClk);
        CtrlMemRdQ102H = 0; CtrlMemWrQ102H = 0;
        force dut.cycleCnt = 32'hFFFF_FFFE;
        cycSetVal = 32'hFFFF_FFFE;
        cycSetReq++;
        #1 release dut.cycleCnt;
        req(1, 0, 32'h200C, 0, 4'hF); chk("cycPreWrap", MemRdDataQ103H, 32'hFFFFFFFF);
        req(1, 0, 32'h200C, 0, 4'hF); chk("cycWrap", MemRdDataQ103H, 32'h0);

        for (int n = 0; n < 3000; n++) begin
            if (n % 600 == 599) begin
                doReset();
                continue;
            end
            r = int'($urandom_range(99));
            c = int'($urandom_range(9));
            be = ($urandom_range(9) < 3) ? 4'h1 : ($urandom_range(9) < 5) ? 4'h3 : 4'hF;
            if ($urandom_range(9) == 0) be = 4'($urandom_range(15));
            off = (be == 4'h1) ? int'($urandom_range(3)) : (be == 4'h3) ? 2 * int'($urandom_range(1)) : 0;
            if (c == 6) off = int'($urandom_range(3));
            a = (c < 7) ? 32'h1000 + 4 * $urandom_range(1023) + 32'(off) :
                (c < 9) ? 32'h2000 + 4 * $urandom_range(3) + 32'(off) : $urandom;
            req(r < 45 || (r >= 90 && r < 95), r >= 45 && r < 95, a, $urandom, be);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
        $finish;
    end
endmodule
